// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher
// Request-side initiator for the elevator car controller. Call requests
// (origin, destination) are buffered in a small FIFO and presented one at a
// time on en/in_origin/destination, sequenced against the car's idle status.
// destination is held for the whole trip because the car compares against the
// live input rather than a latched copy.
// Optional feature macro: DISPATCH_DUP_FILTER_EN. When defined, a valid call
// that matches a queued or in-service request is accepted but not enqueued.
module elevator_call_dispatcher #(
    parameter int unsigned NUM_FLOORS  = 5,
    parameter int unsigned FLOOR_W     = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   call_valid,
    input  logic [FLOOR_W-1:0]     call_origin,
    input  logic [FLOOR_W-1:0]     call_dest,
    output logic                   call_ready,
    output logic                   call_reject,
    input  logic                   idle,
    output logic                   en,
    output logic [FLOOR_W-1:0]     in_origin,
    output logic [FLOOR_W-1:0]     destination,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             served_count,
    output logic                   timeout_err
);

    localparam int unsigned        AW          = $clog2(DEPTH);
    localparam int unsigned        TW          = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]        FULL_COUNT  = (AW + 1)'(DEPTH);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [TW-1:0]      TMO_LAST    = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_SERVE
    } state_t;

    state_t             state;
    logic [FLOOR_W-1:0] mem_origin [DEPTH];
    logic [FLOOR_W-1:0] mem_dest   [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [TW-1:0]      tmo_cnt;
    logic               invalid_call;
    logic               dup_hit;
    logic               push;
    logic               pop;

    assign invalid_call = ({1'b0, call_origin} >= FLOOR_LIMIT) ||
                          ({1'b0, call_dest}   >= FLOOR_LIMIT) ||
                          (call_origin == call_dest);

`ifdef DISPATCH_DUP_FILTER_EN
    // Match the offered call against every occupied FIFO slot and the request in service
    always_comb begin
        dup_hit = 1'b0;
        if (state != S_IDLE && in_origin == call_origin && destination == call_dest)
            dup_hit = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - rd_ptr} < fifo_count) &&
                mem_origin[AW'(i)] == call_origin && mem_dest[AW'(i)] == call_dest)
                dup_hit = 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    assign call_ready = (fifo_count != FULL_COUNT);
    assign push       = call_valid && call_ready && !invalid_call && !dup_hit;
    assign pop        = (state == S_IDLE) && (fifo_count != '0) && idle;
    assign busy       = (state != S_IDLE);

    // Call storage; occupancy is tracked by fifo_count, so contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_origin[wr_ptr] <= call_origin;
            mem_dest[wr_ptr]   <= call_dest;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + (AW + 1)'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - (AW + 1)'(1);
        end
    end

    // One-cycle reject pulse for a malformed call; ready is irrelevant here
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            call_reject <= 1'b0;
        else
            call_reject <= call_valid && invalid_call;
    end

    // Request sequencer: dispatch head, wait for car acknowledge, wait for trip end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            en           <= 1'b0;
            in_origin    <= '0;
            destination  <= '0;
            tmo_cnt      <= '0;
            served_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        in_origin   <= mem_origin[rd_ptr];
                        destination <= mem_dest[rd_ptr];
                        en          <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!idle) begin
                        en    <= 1'b0;
                        state <= S_SERVE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        en          <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_SERVE: begin
                    if (idle) begin
                        served_count <= served_count + 8'd1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb_elevator_call_dispatcher
// Drives directed and random call traffic plus a behavioural car model and
// compares the dispatcher against a queue-based scoreboard.
module tb_elevator_call_dispatcher;

    localparam int NF    = 5;
    localparam int FW    = 3;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;
`ifdef DISPATCH_DUP_FILTER_EN
    localparam bit DUP_ON = 1'b1;
`else
    localparam bit DUP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          call_valid;
    logic [FW-1:0] call_origin;
    logic [FW-1:0] call_dest;
    logic          call_ready;
    logic          call_reject;
    logic          idle;
    logic          en;
    logic [FW-1:0] in_origin;
    logic [FW-1:0] destination;
    logic          busy;
    logic [2:0]    fifo_count;
    logic [7:0]    served_count;
    logic          timeout_err;

    elevator_call_dispatcher #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .DEPTH      (DEPTH),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .call_valid  (call_valid),
        .call_origin (call_origin),
        .call_dest   (call_dest),
        .call_ready  (call_ready),
        .call_reject (call_reject),
        .idle        (idle),
        .en          (en),
        .in_origin   (in_origin),
        .destination (destination),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .served_count(served_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o;
        int d;
    } call_t;

    call_t q[$];
    call_t svc;
    int    n_tests    = 0;
    int    n_fail     = 0;
    int    served_m   = 0;
    bit    tmo_m      = 1'b0;
    int    car_ph     = 0;   // 0 waiting, 1 ack delay, 2 trip, 3 ignoring, 4 trip done
    int    dly        = 0;
    int    trip       = 0;
    int    high       = 0;
    bit    in_svc     = 1'b0;
    bit    en_prev    = 1'b0;
    bit    car_block  = 1'b0;
    int    force_ign  = -1;
    int    force_dly  = -1;
    int    force_trip = -1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_dup(input int o, input int d);
        bit hit = 1'b0;
        if (in_svc && svc.o == o && svc.d == d) hit = 1'b1;
        foreach (q[i]) if (q[i].o == o && q[i].d == d) hit = 1'b1;
        return hit && DUP_ON;
    endfunction

    function automatic int pick_trip();
        return (force_trip < 0) ? int'($urandom_range(1, 4)) : force_trip;
    endfunction

    task automatic check_held(input string tag);
        check({tag, "_origin"}, int'(in_origin), svc.o);
        check({tag, "_dest"}, int'(destination), svc.d);
    endtask

    task automatic model_reset();
        q.delete();
        served_m  = 0;
        tmo_m     = 1'b0;
        car_ph    = 0;
        in_svc    = 1'b0;
        en_prev   = 1'b0;
        car_block = 1'b0;
        idle      = 1'b1;
    endtask

    // One clock: account for the edge just taken, run the car, check, drive idle
    task automatic tick();
        int    o;
        int    d;
        bit    valid_call;
        bit    exp_rej;
        bit    ign;
        call_t c;
        @(negedge clk);
        o          = int'(call_origin);
        d          = int'(call_dest);
        valid_call = (o < NF) && (d < NF) && (o != d);
        exp_rej    = call_valid && !valid_call;
        if (call_valid && valid_call && q.size() < DEPTH && !is_dup(o, d)) begin
            c.o = o;
            c.d = d;
            q.push_back(c);
        end
        check("call_reject", int'(call_reject), int'(exp_rej));

        case (car_ph)
            0: begin
                if (en && !en_prev) begin
                    check("en_with_queue", int'(q.size() != 0), 1);
                    if (q.size() != 0) svc = q.pop_front();
                    check_held("req");
                    check("busy_on_req", int'(busy), 1);
                    in_svc = 1'b1;
                    high   = 1;
                    if (force_ign < 0) ign = ($urandom_range(0, 15) == 0);
                    else               ign = (force_ign != 0);
                    if (ign) begin
                        car_ph = 3;
                    end else begin
                        dly = (force_dly < 0) ? int'($urandom_range(0, 2)) : force_dly;
                        if (dly == 0) begin
                            car_ph = 2;
                            trip   = pick_trip();
                        end else begin
                            car_ph = 1;
                        end
                    end
                end else begin
                    check("en_low_idle", int'(en), 0);
                    check("busy_low_idle", int'(busy), 0);
                end
            end
            1: begin
                check("en_hold_ack", int'(en), 1);
                check("busy_ack", int'(busy), 1);
                check_held("ack");
                dly--;
                if (dly == 0) begin
                    car_ph = 2;
                    trip   = pick_trip();
                end
            end
            2: begin
                check("en_low_serve", int'(en), 0);
                check("busy_serve", int'(busy), 1);
                check_held("serve");
                trip--;
                if (trip == 0) car_ph = 4;
            end
            3: begin
                if (en) begin
                    high++;
                    check("ack_wait_len", int'(high <= TMO), 1);
                    check_held("wait");
                end else begin
                    check("timeout_len", high, TMO);
                    check("busy_after_tmo", int'(busy), 0);
                    tmo_m  = 1'b1;
                    in_svc = 1'b0;
                    car_ph = 0;
                end
            end
            default: begin
                check("en_low_done", int'(en), 0);
                check("busy_done", int'(busy), 0);
                served_m++;
                in_svc = 1'b0;
                car_ph = 0;
            end
        endcase

        check("fifo_count", int'(fifo_count), q.size());
        check("call_ready", int'(call_ready), int'(q.size() < DEPTH));
        check("served_count", int'(served_count), served_m % 256);
        check("timeout_err", int'(timeout_err), int'(tmo_m));
        en_prev = en;
        case (car_ph)
            0:       idle = !car_block;
            2:       idle = 1'b0;
            default: idle = 1'b1;
        endcase
    endtask

    task automatic offer(input int o, input int d);
        call_valid  = 1'b1;
        call_origin = FW'(o);
        call_dest   = FW'(d);
        tick();
        call_valid  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        call_valid  = 1'b0;
        call_origin = '0;
        call_dest   = '0;
        idle        = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_en", int'(en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fifo", int'(fifo_count), 0);
        check("rst_origin", int'(in_origin), 0);
        check("rst_dest", int'(destination), 0);
        check("rst_reject", int'(call_reject), 0);
        check("rst_served", int'(served_count), 0);
        check("rst_tmo", int'(timeout_err), 0);
        reset = 1'b0;
        model_reset();
        #1;
        check("ready_after_rst", int'(call_ready), 1);

        // Single trip, car acknowledges two cycles after en
        force_ign  = 0;
        force_dly  = 2;
        force_trip = 2;
        offer(1, 3);
        tick();
        check("lat_en", int'(en), 1);
        check("lat_origin", int'(in_origin), 1);
        check("lat_dest", int'(destination), 3);
        repeat (8) tick();
        check("served_one", int'(served_count), 1);

        // Fill the FIFO while the car is busy elsewhere, then drain in order
        force_dly  = -1;
        force_trip = -1;
        car_block  = 1'b1;
        idle       = 1'b0;
        call_valid = 1'b1;
        call_origin = 3'd0; call_dest = 3'd4; tick();
        call_origin = 3'd2; call_dest = 3'd1; tick();
        call_origin = 3'd3; call_dest = 3'd0; tick();
        call_origin = 3'd4; call_dest = 3'd2; tick();
        call_origin = 3'd1; call_dest = 3'd0; tick();
        call_valid = 1'b0;
        check("full_count", int'(fifo_count), 4);
        check("full_ready", int'(call_ready), 0);
        car_block = 1'b0;
        repeat (60) tick();
        check("drain_fifo", int'(fifo_count), 0);
        check("served_five", int'(served_count), 5);

        // Malformed calls
        car_block = 1'b1;
        idle      = 1'b0;
        offer(5, 1);
        check("rej_a", int'(call_reject), 1);
        offer(2, 7);
        check("rej_b", int'(call_reject), 1);
        offer(3, 3);
        check("rej_c", int'(call_reject), 1);
        tick();
        check("rej_fifo", int'(fifo_count), 0);

        // Car never acknowledges
        car_block = 1'b0;
        idle      = 1'b1;
        force_ign = 1;
        offer(1, 2);
        repeat (25) tick();
        check("tmo_flag", int'(timeout_err), 1);
        check("tmo_fifo", int'(fifo_count), 0);
        check("tmo_busy", int'(busy), 0);
        force_ign = 0;

        // Call inputs move during a trip; then reset lands mid-trip
        force_dly  = 0;
        force_trip = 10;
        offer(3, 1);
        for (int i = 0; i < 10 && car_ph != 2; i++) tick();
        check("in_trip", car_ph, 2);
        offer(0, 2);
        offer(4, 3);
        offer(1, 4);
        tick();
        check("trip_dest_held", int'(destination), 1);
        #2 reset = 1'b1;
        #1;
        check("async_en", int'(en), 0);
        check("async_fifo", int'(fifo_count), 0);
        check("async_busy", int'(busy), 0);
        check("async_served", int'(served_count), 0);
        check("async_tmo", int'(timeout_err), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Duplicate calls while the car is unavailable
        car_block = 1'b1;
        idle      = 1'b0;
        call_valid = 1'b1;
        call_origin = 3'd2; call_dest = 3'd4; tick();
        tick();
        call_valid = 1'b0;
        tick();
        check("dup_count", int'(fifo_count), DUP_ON ? 1 : 2);
        car_block = 1'b0;

        // Random traffic against a randomly behaving car
        force_ign  = -1;
        force_dly  = -1;
        force_trip = -1;
        for (int i = 0; i < 3000; i++) begin
            call_valid  = ($urandom_range(0, 1) == 1);
            call_origin = FW'($urandom_range(0, 5));
            call_dest   = FW'($urandom_range(0, 5));
            if ($urandom_range(0, 63) == 0) car_block = !car_block;
            tick();
        end
        call_valid = 1'b0;
        car_block  = 1'b0;
        force_ign  = 0;
        repeat (100) tick();
        check("final_drain", int'(fifo_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
